contador_ad_bcd_mod: RTL and testbench
======================================

CONTADOR_AD_BCD_MOD -- requirements
Module: contador_ad_bcd_mod

Interface
REQ-001 SHALL have parameter MOD_MAX, default 23: highest count value, inclusive.
REQ-002 SHALL have parameter MIN_VAL, default 0: lowest count value (1 for day/month use).
REQ-003 SHALL have parameter N_DIG, default 2: number of BCD output digits.
REQ-004 SHALL have parameter SEL_ID, default 3: en_count code that selects this counter for editing.
REQ-005 SHALL require W = ceil(log2(MOD_MAX+1)); legal configurations satisfy MIN_VAL < MOD_MAX < 10^N_DIG.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge system clock.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 en_count  input  4  edit-field selector; editing is active when en_count == SEL_ID.
REQ-010 enUP  input  1  edit increment request; level-sampled each cycle.
REQ-011 enDOWN  input  1  edit decrement request; level-sampled each cycle.
REQ-012 tick  input  1  auto-advance pulse (cascade carry from the lower field).
REQ-013 load  input  1  synchronous load strobe.
REQ-014 load_data  input  W  binary value to load.
REQ-015 count_bin  output  W  registered binary count.
REQ-016 data_bcd  output  4*N_DIG  registered BCD of count_bin, most significant digit first.
REQ-017 carry  output  1  one-cycle pulse on a tick-driven wrap from MOD_MAX to MIN_VAL.
REQ-018 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-019 SHALL evaluate one action per clk edge, in priority order: reset > load > edit > tick > hold.
REQ-020 Load
- load=1 with MIN_VAL <= load_data <= MOD_MAX: count_bin <= load_data.
- Otherwise: count unchanged and load_err=1 for one cycle.
REQ-021 Edit
- Active when en_count==SEL_ID and exactly one of enUP/enDOWN is high.
- enUP: count+1, wrapping from MOD_MAX to MIN_VAL.
- enDOWN: count-1, wrapping from MIN_VAL to MOD_MAX.
- enUP and enDOWN both high: hold.
REQ-022 An edit wrap SHALL NOT assert carry.
REQ-023 When en_count==SEL_ID, tick SHALL be ignored, even if enUP and enDOWN are both low.
REQ-024 Tick: count+1; at MOD_MAX the count wraps to MIN_VAL and carry=1 in the same cycle the count shows MIN_VAL.
REQ-025 carry and load_err SHALL be registered and zero in every cycle without their triggering event.
REQ-026 data_bcd SHALL lag count_bin by exactly one clock: a registered binary-to-BCD conversion of the previous count_bin.
REQ-027 Arithmetic SHALL be W-bit unsigned and compare against MOD_MAX/MIN_VAL before incrementing or decrementing, so no out-of-range value is ever registered.
REQ-028 If count_bin is ever out of range, the next increment/decrement SHALL force MIN_VAL.

Reset
REQ-029 reset=1 at a clk edge: count_bin=MIN_VAL, carry=0, load_err=0; regardless of all other inputs.
REQ-030 data_bcd SHALL equal BCD(MIN_VAL) at the first edge with reset high; no one-cycle latency applies during reset.
REQ-031 Reset asserted mid-edit or coincident with tick/load SHALL win; the pending action is discarded.

Verification (defaults: MOD_MAX=23, MIN_VAL=0, N_DIG=2, SEL_ID=3)
REQ-032 Reset with load=1, load_data=9 -> count_bin=0, data_bcd=8'h00, carry=0.
REQ-033 load 23, then one tick -> count_bin=0 and carry=1 for one cycle; next cycle data_bcd=8'h00.
REQ-034 en_count=3, enDOWN=1 from 0 -> 23, then 22; data_bcd=8'h23, then 8'h22; carry stays 0.
REQ-035 en_count=3, enUP=enDOWN=0, tick=1 -> count holds; en_count=3, enUP=enDOWN=1 -> count holds.
REQ-036 load_data=24 -> load_err=1 for one cycle, count unchanged; load_data=17 -> data_bcd=8'h17 one cycle after count_bin=17.
REQ-037 MIN_VAL=1, MOD_MAX=31: tick at 31 -> count_bin=1, carry=1; enDOWN at 1 -> 31.

Source files
------------

// File: rtl/contador_ad_bcd_mod.sv
`default_nettype none
// ============================================================================
// contador_ad_bcd_mod : editable modulo counter (MIN_VAL..MOD_MAX), BCD output
// Revision: 1.0
// ============================================================================
module contador_ad_bcd_mod #(
  parameter  int MOD_MAX = 23,
  parameter  int MIN_VAL = 0,
  parameter  int N_DIG   = 2,
  parameter  int SEL_ID  = 3,
  localparam int W       = $clog2(MOD_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         en_count,
  input  logic               enUP,
  input  logic               enDOWN,
  input  logic               tick,
  input  logic               load,
  input  logic [W-1:0]       load_data,
  output logic [W-1:0]       count_bin,
  output logic [4*N_DIG-1:0] data_bcd,
  output logic               carry,
  output logic               load_err
);

  localparam logic [W-1:0] MAX_W  = MOD_MAX[W-1:0];
  localparam logic [W-1:0] MIN_W  = MIN_VAL[W-1:0];
  localparam logic [W-1:0] SPAN_W = W'(MOD_MAX - MIN_VAL);
  localparam logic [3:0]   SEL_W  = SEL_ID[3:0];

  // Double-dabble conversion; digits are rotated through the low nibble so
  // no variable part-select is needed.
  function automatic logic [4*N_DIG-1:0] to_bcd(input logic [W-1:0] bin);
    logic [4*N_DIG-1:0] acc;
    logic [4*N_DIG+3:0] ext;
    logic [W-1:0]       bits;
    logic [3:0]         nib;
    acc  = '0;
    bits = bin;
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < N_DIG; d++) begin
        nib = acc[3:0];
        if (nib >= 4'd5) nib = nib + 4'd3;
        ext = {nib, acc};
        acc = ext[4*N_DIG+3:4];
      end
      acc  = {acc[4*N_DIG-2:0], bits[W-1]};
      bits = bits << 1;
    end
    return acc;
  endfunction

  localparam logic [4*N_DIG-1:0] BCD_MIN = to_bcd(MIN_W);

  logic [W-1:0] count_next;
  logic         carry_next;
  logic         err_next;
  logic [W-1:0] offset;
  logic [W-1:0] load_offset;
  logic         in_range;
  logic         load_ok;
  logic         at_max;
  logic         at_min;
  logic         edit_sel;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;

  // Single unsigned compare covers both bounds: (x - MIN) wraps large when x < MIN.
  assign offset      = count_bin - MIN_W;
  assign load_offset = load_data - MIN_W;
  assign in_range    = (offset <= SPAN_W);
  assign load_ok     = (load_offset <= SPAN_W);
  assign at_max      = (count_bin == MAX_W);
  assign at_min      = (count_bin == MIN_W);
  assign edit_sel    = (en_count == SEL_W);

  assign inc_val = (!in_range || at_max) ? MIN_W : count_bin + 1'b1;
  assign dec_val = !in_range ? MIN_W : (at_min ? MAX_W : count_bin - 1'b1);

  always_comb begin
    count_next = count_bin;
    carry_next = 1'b0;
    err_next   = 1'b0;
    if (load) begin
      if (load_ok) count_next = load_data;
      else         err_next   = 1'b1;
    end else if (edit_sel) begin
      // Selected for editing: tick is ignored and edit wraps never carry.
      if (enUP && !enDOWN)      count_next = inc_val;
      else if (enDOWN && !enUP) count_next = dec_val;
    end else if (tick) begin
      count_next = inc_val;
      carry_next = at_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_bin <= MIN_W;
      data_bcd  <= BCD_MIN;
      carry     <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      count_bin <= count_next;
      data_bcd  <= to_bcd(count_bin);
      carry     <= carry_next;
      load_err  <= err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_contador_ad_bcd_mod.sv
`default_nettype none
// ============================================================================
// tb_contador_ad_bcd_mod : scoreboard bench for two counter configurations
// Revision: 1.0
// ============================================================================
module tb_contador_ad_bcd_mod;

  logic       clk = 1'b0;
  logic       reset, enUP, enDOWN, tick, load;
  logic [3:0] en_count;
  logic [4:0] load_data;

  logic [4:0] cnt_a, cnt_b;
  logic [7:0] bcd_a, bcd_b;
  logic       carry_a, carry_b, err_a, err_b;

  always #5 clk = ~clk;

  contador_ad_bcd_mod dut_a (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .tick(tick), .load(load), .load_data(load_data),
    .count_bin(cnt_a), .data_bcd(bcd_a), .carry(carry_a), .load_err(err_a)
  );

  contador_ad_bcd_mod #(.MOD_MAX(31), .MIN_VAL(1), .N_DIG(2), .SEL_ID(3)) dut_b (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .tick(tick), .load(load), .load_data(load_data),
    .count_bin(cnt_b), .data_bcd(bcd_b), .carry(carry_b), .load_err(err_b)
  );

  typedef struct packed {
    int   cnt;
    logic carry;
    logic err;
  } res_t;

  typedef struct packed {
    res_t       a;
    logic [7:0] bcd_a;
    res_t       b;
    logic [7:0] bcd_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_a      = 0;
  int   m_b      = 1;

  function automatic logic [7:0] bcd_of(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic res_t model(input int c, input int mn, input int mx,
                                 input bit rst, input bit ld, input int ldd,
                                 input int enc, input bit up, input bit dn,
                                 input bit tk);
    res_t r;
    r.cnt = c; r.carry = 1'b0; r.err = 1'b0;
    if (rst) r.cnt = mn;
    else if (ld) begin
      if (ldd >= mn && ldd <= mx) r.cnt = ldd;
      else                        r.err = 1'b1;
    end else if (enc == 3) begin
      if (up && !dn)      r.cnt = (c == mx) ? mn : c + 1;
      else if (dn && !up) r.cnt = (c == mn) ? mx : c - 1;
    end else if (tk) begin
      if (c == mx) begin r.cnt = mn; r.carry = 1'b1; end
      else r.cnt = c + 1;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit ld, input int ldd, input int enc,
                      input bit up, input bit dn, input bit tk);
    exp_t e;
    @(negedge clk);
    reset = rst; load = ld; load_data = 5'(ldd); en_count = 4'(enc);
    enUP = up; enDOWN = dn; tick = tk;
    e.a     = model(m_a, 0, 23, rst, ld, ldd, enc, up, dn, tk);
    e.b     = model(m_b, 1, 31, rst, ld, ldd, enc, up, dn, tk);
    e.bcd_a = rst ? bcd_of(0) : bcd_of(m_a);
    e.bcd_b = rst ? bcd_of(1) : bcd_of(m_b);
    exp_q.push_back(e);
    m_a = e.a.cnt;
    m_b = e.b.cnt;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a.count",    int'(cnt_a),   e.a.cnt);
        chk("a.bcd",      int'(bcd_a),   int'(e.bcd_a));
        chk("a.carry",    int'(carry_a), int'(e.a.carry));
        chk("a.load_err", int'(err_a),   int'(e.a.err));
        chk("b.count",    int'(cnt_b),   e.b.cnt);
        chk("b.bcd",      int'(bcd_b),   int'(e.bcd_b));
        chk("b.carry",    int'(carry_b), int'(e.b.carry));
        chk("b.load_err", int'(err_b),   int'(e.b.err));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; load = 1'b0; load_data = '0; en_count = '0;
    enUP = 1'b0; enDOWN = 1'b0; tick = 1'b0;

    // Reset overrides a coincident load and tick.
    step(1, 1, 9, 0, 0, 0, 1);
    step(1, 0, 0, 3, 1, 0, 0);
    // Load max then tick: wrap with carry, BCD follows a cycle later.
    step(0, 1, 23, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    // Edit down from the minimum wraps to the maximum without carry.
    step(0, 0, 0, 3, 0, 1, 0);
    step(0, 0, 0, 3, 0, 1, 0);
    step(0, 0, 0, 3, 0, 0, 0);
    // Selected field ignores tick; both edit requests hold.
    step(0, 0, 0, 3, 0, 0, 1);
    step(0, 0, 0, 3, 1, 1, 1);
    // Out-of-range and in-range loads.
    step(0, 1, 24, 0, 0, 0, 0);
    step(0, 1, 17, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // Second configuration: tick at 31 wraps to 1, edit-down at 1 wraps to 31.
    step(0, 1, 31, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 3, 0, 1, 0);
    step(0, 0, 0, 3, 1, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1);
    // Mid-edit reset.
    step(1, 0, 0, 3, 1, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 8),
           int'($urandom_range(0, 31)),
           ($urandom_range(0, 99) < 45) ? 3 : int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 99) < 60));
    end

    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
